// File: rtl/column_scanner.sv
`default_nettype none
// =============================================================================
// Module   : column_scanner
// Purpose  : Drives one column of a multiplexed LED matrix at a time, with a
//            blanking gap between columns and a frame-start strobe.
// Revision : 1.0
// =============================================================================
module column_scanner #(
   parameter int N_COLS       = 5,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 2,
   parameter int ACTIVE_LOW   = 0,
   localparam int CW          = (N_COLS > 2) ? $clog2(N_COLS) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   output logic [N_COLS-1:0] col_out,
   output logic [CW-1:0]     col_idx,
   output logic              blank,
   output logic              frame_start
);

   localparam int c_CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int c_CNTW    = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

   localparam logic [c_CNTW-1:0] c_DWELL_LAST = c_CNTW'(DWELL_CYCLES - 1);
   localparam logic [c_CNTW-1:0] c_BLANK_LAST = c_CNTW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [CW-1:0]     c_IDX_LAST   = CW'(N_COLS - 1);
   localparam logic [N_COLS-1:0] c_COL_ONE    = N_COLS'(1);
   localparam logic [N_COLS-1:0] c_COL_OFF    = {N_COLS{ACTIVE_LOW != 0}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_DRIVE = 2'd2;

   // With no blanking gap the scanner moves straight from column to column.
   localparam logic [1:0] c_GAP_STATE = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

   logic [1:0]        state_q,   state_d;
   logic [c_CNTW-1:0] cnt_q,     cnt_d;
   logic [CW-1:0]     idx_q,     idx_d;
   logic [N_COLS-1:0] col_out_q, col_out_d;
   logic              blank_q,   blank_d;
   logic              fs_q,      fs_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         col_out_q <= c_COL_OFF;
         blank_q   <= 1'b1;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         col_out_q <= col_out_d;
         blank_q   <= blank_d;
         fs_q      <= fs_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (!en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = c_GAP_STATE;
               cnt_d   = '0;
               idx_d   = '0;
            end
            S_BLANK: begin
               if (cnt_q == c_BLANK_LAST) begin
                  state_d = S_DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + c_CNTW'(1);
               end
            end
            S_DRIVE: begin
               if (cnt_q == c_DWELL_LAST) begin
                  state_d = c_GAP_STATE;
                  cnt_d   = '0;
                  idx_d   = (idx_q == c_IDX_LAST) ? '0 : idx_q + CW'(1);
               end else begin
                  cnt_d = cnt_q + c_CNTW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Outputs are computed from the next state so they register on the same edge.
   always_comb begin
      col_out_d = c_COL_OFF;
      blank_d   = 1'b1;
      fs_d      = 1'b0;
      if (state_d == S_DRIVE) begin
         col_out_d = (c_COL_ONE << idx_d) ^ c_COL_OFF;
         blank_d   = 1'b0;
         fs_d      = (cnt_d == '0) && (idx_d == '0);
      end
   end

   assign col_out     = col_out_q;
   assign col_idx     = idx_q;
   assign blank       = blank_q;
   assign frame_start = fs_q;

endmodule
`default_nettype wire
